// File: rtl/alu16_seq.sv
// Two-pass 16-bit arithmetic sequencer driving an 8-bit ALU (low byte, then high byte).
// Latency: accept at edge N, result registered at edge N+2, rsp_valid high from then; 4 cycles/op minimum.
// Backpressure: req_ready only in IDLE; the response is held stable in DONE until rsp_ready.

package alu16_seq_pkg;
  // Flag nibble ordered {Z,N,H,C}
  typedef logic [3:0] flags_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_ADC  = 3'd2,
    ALU_SUB  = 3'd3,
    ALU_SBC  = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    OP_ADD16 = 2'b00,
    OP_ADDSP = 2'b01,
    OP_INC16 = 2'b10,
    OP_DEC16 = 2'b11
  } seq_op_t;
endpackage

module alu16_seq
  import alu16_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  flags_t      flags_cur,
  output logic        alu_en,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output alu_op_t     alu_op,
  output flags_t      alu_flags_in,
  input  logic [7:0]  alu_res,
  input  flags_t      alu_flags_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output flags_t      rsp_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  seq_op_t     op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  flags_t      flags_q, flags_d;
  logic [7:0]  lo_res_q, lo_res_d;
  flags_t      lo_flags_q, lo_flags_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  flags_t      rsp_flags_q, rsp_flags_d;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed two ALU passes, then wait for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = S_LO;
      S_LO:    state_d = S_HI;
      S_HI:    state_d = S_DONE;
      S_DONE:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath captures: request on accept, low-byte pass in LO, response at end of HI
  always_comb begin
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    flags_d      = flags_q;
    lo_res_d     = lo_res_q;
    lo_flags_d   = lo_flags_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = seq_op_t'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          flags_d = flags_cur;
        end
      end
      S_LO: begin
        lo_res_d   = alu_res;
        lo_flags_d = alu_flags_out;
      end
      S_HI: begin
        rsp_result_d = {alu_res, lo_res_q};
        case (op_q)
          // H/C are the bit-11 and bit-15 carries from the high-byte pass
          OP_ADD16: rsp_flags_d = {flags_q[3], 3'b000} | (alu_flags_out & 4'b0011);
          // H/C are the unsigned bit-3 and bit-7 carries from the low-byte pass
          OP_ADDSP: rsp_flags_d = lo_flags_q & 4'b0011;
          default:  rsp_flags_d = flags_q;
        endcase
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q         <= OP_ADD16;
      a_q          <= 16'h0000;
      b_q          <= 16'h0000;
      flags_q      <= 4'b0000;
      lo_res_q     <= 8'h00;
      lo_flags_q   <= 4'b0000;
      rsp_result_q <= 16'h0000;
      rsp_flags_q  <= 4'b0000;
    end else begin
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      flags_q      <= flags_d;
      lo_res_q     <= lo_res_d;
      lo_flags_q   <= lo_flags_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  // Outputs: handshakes are pure state decodes; ALU drive depends on pass and op
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    rsp_valid    = (state_q == S_DONE);
    rsp_result   = rsp_result_q;
    rsp_flags    = rsp_flags_q;
    alu_en       = 1'b0;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    alu_op       = ALU_PASS;
    alu_flags_in = flags_q;
    case (state_q)
      S_LO: begin
        alu_en = 1'b1;
        alu_a  = a_q[7:0];
        case (op_q)
          OP_ADD16: begin alu_op = ALU_ADD; alu_b = b_q[7:0]; end
          OP_ADDSP: begin alu_op = ALU_ADD; alu_b = b_q[7:0]; end
          OP_INC16: begin alu_op = ALU_ADD; alu_b = 8'h01;    end
          default:  begin alu_op = ALU_SUB; alu_b = 8'h01;    end
        endcase
      end
      S_HI: begin
        alu_en       = 1'b1;
        alu_a        = a_q[15:8];
        alu_flags_in = {flags_q[3:1], lo_flags_q[0]};
        case (op_q)
          OP_ADD16: begin alu_op = ALU_ADC; alu_b = b_q[15:8]; end
          // Sign extension of e8 into the high byte
          OP_ADDSP: begin alu_op = ALU_ADC; alu_b = {8{b_q[7]}}; end
          OP_INC16: begin alu_op = ALU_ADC; alu_b = 8'h00;       end
          default:  begin alu_op = ALU_SBC; alu_b = 8'h00;       end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu16_seq.sv
// Testbench for alu16_seq: behavioural 8-bit ALU stub plus a 16-bit reference model.
// Stimulus is driven and sampled on the falling clock edge.
module tb_alu16_seq;
  import alu16_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  flags_t      flags_cur;
  logic        alu_en;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  alu_op_t     alu_op;
  flags_t      alu_flags_in;
  logic [7:0]  alu_res;
  flags_t      alu_flags_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  flags_t      rsp_flags;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu16_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flags_cur(flags_cur),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_flags_in(alu_flags_in), .alu_res(alu_res), .alu_flags_out(alu_flags_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  // Combinational 8-bit ALU seen by the sequencer; C is carry on add, borrow on subtract
  always_comb begin
    int x, y, ci, s, hs;
    x = int'(alu_a);
    y = int'(alu_b);
    ci = int'(alu_flags_in[0]);
    s = 0;
    hs = 0;
    alu_res = alu_a;
    alu_flags_out = alu_flags_in;
    case (alu_op)
      ALU_ADD, ALU_ADC: begin
        if (alu_op == ALU_ADD) ci = 0;
        s = x + y + ci;
        hs = (x & 15) + (y & 15) + ci;
        alu_res = 8'(s);
        alu_flags_out = {(8'(s) == 8'h00), 1'b0, (hs > 15), (s > 255)};
      end
      ALU_SUB, ALU_SBC: begin
        if (alu_op == ALU_SUB) ci = 0;
        s = x - y - ci;
        hs = (x & 15) - (y & 15) - ci;
        alu_res = 8'(s);
        alu_flags_out = {(8'(s) == 8'h00), 1'b1, (hs < 0), (s < 0)};
      end
      default: ;
    endcase
  end

  // Whole-word reference: 16-bit arithmetic with carries taken from masked sums
  function automatic void ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] f, output logic [15:0] r, output logic [3:0] fl);
    int ai, bi, e;
    ai = int'(a);
    bi = int'(b);
    e = 0;
    r = 16'h0000;
    fl = 4'b0000;
    case (op)
      2'b00: begin
        r = 16'(ai + bi);
        fl = {f[3], 1'b0, (((ai & 'hfff) + (bi & 'hfff)) > 'hfff), ((ai + bi) > 'hffff)};
      end
      2'b01: begin
        e = int'(b[7:0]);
        if (e > 127) e = e - 256;
        r = 16'(ai + e);
        fl = {2'b00, (((ai & 'hf) + (bi & 'hf)) > 'hf), (((ai & 'hff) + (bi & 'hff)) > 'hff)};
      end
      2'b10: begin r = 16'(ai + 1); fl = f; end
      default: begin r = 16'(ai - 1); fl = f; end
    endcase
  endfunction

  // One transaction from IDLE back to IDLE; caller is at a falling edge with the DUT idle
  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, input int rdy_delay,
                       output int lat, output logic [15:0] res, output logic [3:0] flg,
                       output logic lo_ok);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; flags_cur = f;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 16'($urandom); req_b = 16'($urandom); flags_cur = 4'($urandom);
    lo_ok = alu_en && (alu_a == a[7:0]) &&
            (alu_op == ((op == 2'b11) ? ALU_SUB : ALU_ADD));
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    res = rsp_result;
    flg = rsp_flags;
    repeat (rdy_delay) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, alu_en} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_hs: ready/valid/en=%b want 100", {req_ready, rsp_valid, alu_en});
    end
    vectors++;
    if ({rsp_result, rsp_flags, alu_a, alu_b, alu_op, alu_flags_in} !== 43'h0) begin
      miscompares++;
      $display("FAIL reset_data: res=%h fl=%b a=%h b=%h op=%0d fin=%b want all zero/PASS",
               rsp_result, rsp_flags, alu_a, alu_b, alu_op, alu_flags_in);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10};
    logic [15:0] t_a  [6] = '{16'h0FFF, 16'hFFFF, 16'hFFF8, 16'h0000, 16'h0000, 16'h00FF};
    logic [15:0] t_b  [6] = '{16'h0001, 16'h0001, 16'h0008, 16'h00FF, 16'h1234, 16'h5678};
    logic [3:0]  t_f  [6] = '{4'b1000, 4'b0100, 4'b0000, 4'b1111, 4'b1010, 4'b0101};
    logic [15:0] t_r  [6] = '{16'h1000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0100};
    logic [3:0]  t_fl [6] = '{4'b1010, 4'b0011, 4'b0011, 4'b0000, 4'b1010, 4'b0101};
    int lat;
    logic [15:0] res;
    logic [3:0] flg;
    logic lo_ok;
    for (int i = 0; i < 6; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], t_f[i], 0, lat, res, flg, lo_ok);
      vectors++;
      if (lat !== 3) begin
        miscompares++;
        $display("FAIL dir%0d_latency: got %0d want 3", i, lat);
      end
      vectors++;
      if (res !== t_r[i] || flg !== t_fl[i]) begin
        miscompares++;
        $display("FAIL dir%0d_result: got %h/%b want %h/%b", i, res, flg, t_r[i], t_fl[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [15:0] a, b, er, res;
    logic [3:0] f, ef, flg;
    int lat;
    logic lo_ok;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom); a = 16'($urandom); b = 16'($urandom); f = 4'($urandom);
      if (i % 8 == 0) a = 16'hFFFF;
      ref_op(op, a, b, f, er, ef);
      do_op(op, a, b, f, $urandom_range(0, 3), lat, res, flg, lo_ok);
      vectors++;
      if (res !== er || flg !== ef || lat !== 3 || !lo_ok) begin
        miscompares++;
        $display("FAIL rand%0d op=%0d a=%h b=%h f=%b: got %h/%b lat%0d lo%b want %h/%b lat3 lo1",
                 i, op, a, b, f, res, flg, lat, lo_ok, er, ef);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  q_op [8];
    logic [15:0] q_a [8], q_b [8], q_r [8];
    logic [3:0]  q_f [8], q_fl [8];
    int cyc, sent, got, last;
    for (int i = 0; i < 8; i++) begin
      q_op[i] = 2'($urandom); q_a[i] = 16'($urandom); q_b[i] = 16'($urandom); q_f[i] = 4'($urandom);
      ref_op(q_op[i], q_a[i], q_b[i], q_f[i], q_r[i], q_fl[i]);
    end
    cyc = 0; sent = 0; got = 0; last = -1;
    rsp_ready = 1'b1;
    while (got < 8 && cyc < 200) begin
      if (sent < 8) begin
        req_valid = 1'b1; req_op = q_op[sent]; req_a = q_a[sent]; req_b = q_b[sent]; flags_cur = q_f[sent];
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        vectors++;
        if (rsp_result !== q_r[got] || rsp_flags !== q_fl[got]) begin
          miscompares++;
          $display("FAIL b2b%0d: got %h/%b want %h/%b", got, rsp_result, rsp_flags, q_r[got], q_fl[got]);
        end
        got++;
      end
      if (req_ready && sent < 8) begin
        if (last >= 0) begin
          vectors++;
          if (cyc - last !== 4) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles want 4", cyc - last);
          end
        end
        last = cyc;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (got !== 8) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d responses want 8 (timeout)", got);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] er, er2, hold_r;
    logic [3:0] ef, ef2, hold_f;
    int n;
    ref_op(2'b00, 16'h1234, 16'h4321, 4'b0000, er, ef);
    ref_op(2'b11, 16'h8000, 16'h0000, 4'b0110, er2, ef2);
    req_valid = 1'b1; req_op = 2'b00; req_a = 16'h1234; req_b = 16'h4321; flags_cur = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    // Second request held by its source throughout
    req_op = 2'b11; req_a = 16'h8000; req_b = 16'h0000; flags_cur = 4'b0110;
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    hold_r = rsp_result; hold_f = rsp_flags;
    vectors++;
    if (!rsp_valid || hold_r !== er || hold_f !== ef) begin
      miscompares++;
      $display("FAIL bp_first: valid=%b got %h/%b want 1 %h/%b", rsp_valid, hold_r, hold_f, er, ef);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, req_ready, alu_en} !== 3'b100 || rsp_result !== er || rsp_flags !== ef) begin
        miscompares++;
        $display("FAIL bp_hold%0d: v/r/en=%b res=%h fl=%b want 100 %h/%b",
                 i, {rsp_valid, req_ready, alu_en}, rsp_result, rsp_flags, er, ef);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if ({req_ready, rsp_valid, alu_en} !== 3'b100) begin
      miscompares++;
      $display("FAIL bp_release: ready/valid/en=%b want 100", {req_ready, rsp_valid, alu_en});
    end
    @(negedge clk);
    vectors++;
    if ({req_ready, alu_en} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_second_accept: ready/en=%b want 01", {req_ready, alu_en});
    end
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (!rsp_valid || rsp_result !== er2 || rsp_flags !== ef2) begin
      miscompares++;
      $display("FAIL bp_second: valid=%b got %h/%b want 1 %h/%b", rsp_valid, rsp_result, rsp_flags, er2, ef2);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_hi();
    int seen;
    req_valid = 1'b1; req_op = 2'b00; req_a = 16'hABCD; req_b = 16'h1111; flags_cur = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (alu_en !== 1'b1 || alu_op !== ALU_ADC || alu_a !== 8'hAB) begin
      miscompares++;
      $display("FAIL rst_hi_pre: en=%b op=%0d a=%h want 1 ADC ab", alu_en, alu_op, alu_a);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({req_ready, rsp_valid, alu_en} !== 3'b100 ||
        {rsp_result, rsp_flags, alu_a, alu_b, alu_op, alu_flags_in} !== 43'h0) begin
      miscompares++;
      $display("FAIL rst_hi_state: r/v/en=%b res=%h fl=%b a=%h b=%h op=%0d fin=%b want 100 and zeros",
               {req_ready, rsp_valid, alu_en}, rsp_result, rsp_flags, alu_a, alu_b, alu_op, alu_flags_in);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL rst_hi_no_rsp: rsp_valid seen %0d cycles want 0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = 16'h0; req_b = 16'h0;
    flags_cur = 4'b0; rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_in_hi();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
